// File: rtl/piso_serial_transmitter.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and emits it MSB- or LSB-first. Define PISO_PARITY_EN for a trailing even-parity bit.
module piso_serial_transmitter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             msb_first,
  output logic             load_ready,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);
  localparam logic [CW-1:0] LAST_M1 = CW'(WIDTH - 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
`ifdef PISO_PARITY_EN
    , PARITY = 2'd2
`endif
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    count;
  logic             msb_r;
`ifdef PISO_PARITY_EN
  logic             parity_r;
`endif

  logic [WIDTH-1:0] sreg_shifted;
  logic             next_bit;

  // The bit presented after an advance is precomputed so ser_out can stay a register.
  always_comb begin
    sreg_shifted = msb_r ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
    next_bit     = msb_r ? sreg_shifted[WIDTH-1] : sreg_shifted[0];
  end

  assign load_ready = (state == IDLE);

  // NOTE: every state bit, including the data shift register, is reset here so
  // that a mid-frame reset aborts cleanly; there is no memory array to exempt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sreg      <= '0;
      count     <= '0;
      msb_r     <= 1'b0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
`ifdef PISO_PARITY_EN
      parity_r  <= 1'b0;
`endif
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of state, sreg and count.
      case (state)
        IDLE: begin
          if (load_valid) begin
            state     <= SHIFT;
            sreg      <= load_data;
            msb_r     <= msb_first;
            count     <= '0;
            ser_out   <= msb_first ? load_data[WIDTH-1] : load_data[0];
            ser_valid <= 1'b1;
            done      <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_r  <= ^load_data;
`endif
          end
        end

        SHIFT: begin
          if (ser_en) begin
            sreg  <= sreg_shifted;
            count <= count + 1'b1;
            if (count == LAST) begin
`ifdef PISO_PARITY_EN
              state   <= PARITY;
              ser_out <= parity_r;
              done    <= 1'b1;
`else
              state     <= IDLE;
              ser_out   <= 1'b0;
              ser_valid <= 1'b0;
              done      <= 1'b0;
`endif
            end else begin
              ser_out <= next_bit;
`ifndef PISO_PARITY_EN
              done    <= (count == LAST_M1);
`endif
            end
          end
        end

`ifdef PISO_PARITY_EN
        PARITY: begin
          if (ser_en) begin
            state     <= IDLE;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            done      <= 1'b0;
          end
        end
`endif

        default: begin
          state     <= IDLE;
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_piso_serial_transmitter.sv
// Self-checking bench for piso_serial_transmitter (WIDTH=4): directed frames,
// stalls, abort-by-reset and randomized frames checked against a bit-queue model.
`timescale 1ns/1ps
module tb_piso_serial_transmitter;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             load_valid;
  logic [WIDTH-1:0] load_data;
  logic             msb_first;
  logic             load_ready;
  logic             ser_en;
  logic             ser_out;
  logic             ser_valid;
  logic             done;

  int errors = 0;
  int checks = 0;

  piso_serial_transmitter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .msb_first  (msb_first),
    .load_ready (load_ready),
    .ser_en     (ser_en),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: the frame is the word's bits in transmit order, then optional even parity.
  function automatic void build_frame(input logic [WIDTH-1:0] data, input logic msb,
                                      output logic bits[$]);
    bits = {};
    for (int i = 0; i < WIDTH; i++)
      bits.push_back(msb ? data[WIDTH-1-i] : data[i]);
`ifdef PISO_PARITY_EN
    begin
      int ones = 0;
      for (int i = 0; i < WIDTH; i++) ones += int'(data[i]);
      bits.push_back(logic'(ones % 2));
    end
`endif
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ready"}, load_ready, 1);
    check({tag, "_valid"}, ser_valid, 0);
    check({tag, "_out"},   ser_out,   0);
    check({tag, "_done"},  done,      0);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the frame.
  // stall_mode: 0 none, 1 random ser_en, 2 two stall cycles while bit index 1 is shown.
  task automatic run_frame(input logic [WIDTH-1:0] data, input logic msb, input int stall_mode);
    logic bits[$];
    int idx = 0;
    int cycles = 0;
    int held = 0;
    logic en;
    build_frame(data, msb, bits);
    check("accept_ready", load_ready, 1);
    load_valid = 1'b1;
    load_data  = data;
    msb_first  = msb;
    ser_en     = 1'($urandom);
    @(negedge clk);
    while (idx < bits.size() && cycles < 64) begin
      check($sformatf("bit%0d_valid", idx), ser_valid, 1);
      check($sformatf("bit%0d_out", idx),   ser_out,   bits[idx]);
      check($sformatf("bit%0d_done", idx),  done,      idx == bits.size() - 1);
      check($sformatf("bit%0d_ready", idx), load_ready, 0);
      case (stall_mode)
        1:       en = 1'($urandom);
        2:       begin en = !(idx == 1 && held < 2); if (!en) held++; end
        default: en = 1'b1;
      endcase
      ser_en     = en;
      load_valid = 1'($urandom);
      load_data  = WIDTH'($urandom);
      msb_first  = 1'($urandom);
      @(negedge clk);
      if (en) idx++;
      cycles++;
    end
    if (cycles >= 64) check("frame_timeout", cycles, bits.size());
    if (stall_mode == 0) check("frame_len", cycles, bits.size());
    if (stall_mode == 2) check("stall_len", cycles, bits.size() + 2);
    load_valid = 1'b0;
    check_idle("gap");
  endtask

  initial begin
    reset = 1'b0; load_valid = 1'b0; load_data = '0; msb_first = 1'b0; ser_en = 1'b0;
    #3;
    check_idle("rst0");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle("post_rst");

    run_frame(4'b1011, 1'b1, 0);
    run_frame(4'b1011, 1'b0, 0);
    run_frame(4'b1100, 1'b1, 2);

    // Abort: load held high with a competing word mid-frame, then reset after two bits.
    begin
      logic bits[$];
      build_frame(4'b0110, 1'b1, bits);
      load_valid = 1'b1; load_data = 4'b0110; msb_first = 1'b1; ser_en = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check($sformatf("abort_bit%0d", i), ser_out, bits[i]);
        check($sformatf("abort_valid%0d", i), ser_valid, 1);
        load_data = 4'b1111; msb_first = 1'b0;
        @(negedge clk);
      end
      check("abort_bit2", ser_out, bits[2]);
      #2 reset = 1'b0;
      #1 check_idle("abort");
      load_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check_idle("abort_rel");
    end
    run_frame(4'b1001, 1'b1, 0);

    for (int n = 0; n < 40; n++)
      run_frame(WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 1)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
